irrigation_zone_scheduler: RTL and testbench
============================================

// Module: irrigation_zone_scheduler
// PURPOSE
//  Multi-zone successor of the single-bed irrigation controller. Serves N_ZONES beds
//  round-robin. Each bed reporting dry earth is irrigated for a timed slot.
//  Sprinkler or dripper mode is chosen from the air and temperature sensors.
//  Also covers water-level fault checking, the supply valve and the alarm.
//  Sits between the sensor inputs and the LED, 7-segment and matrix display drivers.
// PARAMETERS
//  N_ZONES         4   number of irrigation zones (2..16)
//  TICK_DIV        50  clock cycles per timer tick (>=2)
//  IRRIGATE_TICKS  180 ticks per zone slot (1..2**CNT_W-1)
//  PAUSE_TICKS     5   settle ticks between slots (only with IRRIGATION_PAUSE_EN)
//  CNT_W           8   width of the remaining-time counter
// PORTS
//  clock                  in   1            system clock, rising edge
//  reset                  in   1            asynchronous, active-high
//  low_water_level        in   1            1 = water at or above the low probe
//  mid_water_level        in   1            1 = water at or above the mid probe
//  high_water_level       in   1            1 = water at or above the high probe
//  earth_humidity         in   N_ZONES      per zone: 1 = humid (no need), 0 = dry
//  air_humidity           in   1            1 = humid air
//  low_temperature        in   1            1 = cold
//  enable                 in   1            1 = scheduler allowed to run
//  zone_valve             out  N_ZONES      one-hot open valve; all 0 outside IRRIGATE
//  splinker_bomb          out  1            sprinkler pump on
//  dripper_valvule        out  1            dripper valve on
//  water_supply_valvule   out  1            tank refill valve open
//  alarm                  out  1            fault or low reserve
//  active_zone            out  $clog2(N_ZONES)  zone being or last served
//  remaining              out  CNT_W        ticks left in the current slot or pause
//  state                  out  3            IDLE=0 SCAN=1 IRRIGATE=2 PAUSE=3 FAULT=4
// BEHAVIOUR
//  - Reset: every output is 0. state=IDLE; the scan pointer is 0; the prescaler is 0.
//  - All outputs are registered. Sensor inputs are already synchronised upstream.
//  - conflict = (mid & !low) | (high & !mid) | (high & !low).
//  - fault = conflict | !low_water_level.
//  - Global rules, checked every cycle:
//    - alarm <= conflict | !mid_water_level.
//    - water_supply_valvule <= !high_water_level & !conflict.
//  - Tick: the prescaler counts 0..TICK_DIV-1 and pulses tick on its wrap.
//    - The prescaler clears on entry to IRRIGATE or PAUSE, so the first tick of a slot is full length.
//  - IDLE: if enable & !fault, go to SCAN. If fault, go to FAULT.
//  - SCAN: tests one zone per clock, starting at the pointer.
//    - On earth_humidity[ptr]==0: go to IRRIGATE and set active_zone=ptr.
//      - remaining <= IRRIGATE_TICKS.
//      - Latch mode: sprinkler = mid & !air_humidity & !low_temperature; otherwise dripper.
//    - Otherwise ptr <= ptr+1, wrapping from N_ZONES-1 to 0.
//    - After N_ZONES consecutive misses, go to IDLE. Worst-case latency is N_ZONES clocks.
//  - IRRIGATE:
//    - zone_valve[active_zone]=1, plus the latched pump or valve.
//    - remaining decrements on each tick.
//    - The slot ends when tick occurs with remaining==1, or when earth_humidity[active_zone] rises (early finish).
//    - At slot end: ptr <= active_zone+1 (wrapping), then go to PAUSE (macro on) or SCAN (macro off). remaining <= 0.
//  - Priority in every state, highest first:
//    1. fault goes to FAULT, closing all valves and pumps on the next edge.
//    2. !enable goes to IDLE, closing valves and pumps.
//    3. Normal transitions.
//    - When fault and slot end coincide, fault wins and ptr is not advanced.
//  - FAULT: all zone valves, the pump and the dripper are 0. remaining holds 0. Exit to IDLE when fault clears.
//  - A mode change during a slot is ignored; mode is re-evaluated only on IRRIGATE entry.
//  - Asserting reset mid-slot closes all valves immediately (asynchronous).
//  - No other outputs change except through the rules above.
// CONFIGURATION
//  IRRIGATION_PAUSE_EN defined:
//    - Adds the PAUSE state: all valves closed, remaining <= PAUSE_TICKS, decrement on each tick.
//    - Exit to SCAN on the tick with remaining==1. Fault and enable priority still apply.
//  IRRIGATION_PAUSE_EN undefined:
//    - PAUSE is unreachable; slot end goes directly to SCAN.
//    - PAUSE_TICKS is ignored and the state encoding is unchanged.
// TESTING
//  1. Reset: reset=1 mid-IRRIGATE -> all outputs 0 asynchronously; after release state=0.
//  2. Round-robin: N_ZONES=4, earth_humidity=4'b0101, levels all 1, enable=1, IRRIGATE_TICKS=3.
//     Expected: zone 1 open 3 ticks, then zone 3 open 3 ticks, then zone 1 again.
//  3. Mode: mid=1, air_humidity=0, low_temperature=0 -> splinker_bomb=1. Toggling air_humidity mid-slot has no effect.
//     With mid=0 and low=1 -> dripper_valvule=1, alarm=1.
//  4. Fault: low=1 mid=0 high=1 during IRRIGATE -> next edge state=4, zone_valve=0, alarm=1, water_supply_valvule=0.
//     Clearing the fault -> IDLE, then SCAN.
//  5. Early finish and idle: earth_humidity[active_zone] rises at remaining=100 -> slot ends, ptr advances.
//     All zones humid -> IDLE after exactly 4 SCAN clocks.
//  6. Pause (macro on, PAUSE_TICKS=2): after a slot, state=3 for 2 ticks with valves 0, then SCAN.

Source files
------------

// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler
//   Round-robin irrigation controller for N_ZONES beds. Each dry bed gets a timed
//   slot in sprinkler or dripper mode, chosen when the slot opens. The block also
//   checks the water-level probes for faults and drives the tank refill valve and
//   the alarm. Every output is registered.
//
//   Optional feature macro: IRRIGATION_PAUSE_EN
//     defined   -> a PAUSE state of PAUSE_TICKS ticks runs between slots
//     undefined -> a slot ends directly in SCAN
//
//   Ports
//     clock, reset                   system clock; asynchronous active-high reset
//     low/mid/high_water_level       tank probes (1 = water at or above the probe)
//     earth_humidity[N_ZONES]        per-bed soil sensor (0 = dry, needs water)
//     air_humidity, low_temperature  select the irrigation mode
//     enable                         allows the scheduler to run
//     zone_valve[N_ZONES]            one-hot valve of the bed being irrigated
//     splinker_bomb, dripper_valvule sprinkler pump / dripper valve of the open slot
//     water_supply_valvule, alarm    tank refill valve / fault or low-reserve alarm
//     active_zone, remaining, state  status for the display drivers
module irrigation_zone_scheduler #(
   parameter int N_ZONES        = 4,
   parameter int TICK_DIV       = 50,
   parameter int IRRIGATE_TICKS = 180,
   parameter int PAUSE_TICKS    = 5,
   parameter int CNT_W          = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       low_water_level,
   input  logic                       mid_water_level,
   input  logic                       high_water_level,
   input  logic [N_ZONES-1:0]         earth_humidity,
   input  logic                       air_humidity,
   input  logic                       low_temperature,
   input  logic                       enable,
   output logic [N_ZONES-1:0]         zone_valve,
   output logic                       splinker_bomb,
   output logic                       dripper_valvule,
   output logic                       water_supply_valvule,
   output logic                       alarm,
   output logic [$clog2(N_ZONES)-1:0] active_zone,
   output logic [CNT_W-1:0]           remaining,
   output logic [2:0]                 state
);
   // state     | meaning
   // IDLE  (0) | waiting for enable with healthy water levels
   // SCAN  (1) | testing one bed per clock from the pointer
   // IRRIG (2) | valve of active_zone open, remaining counts ticks
   // PAUSE (3) | settle time between slots, all valves closed
   // FAULT (4) | probe conflict or tank empty, everything closed

   localparam int ZW = $clog2(N_ZONES);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] IRR_LOAD   = CNT_W'(IRRIGATE_TICKS);
   localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_TICKS);
`ifdef IRRIGATION_PAUSE_EN
   localparam bit PAUSE_ON = 1'b1;
`else
   localparam bit PAUSE_ON = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SCAN     = 3'd1,
      S_IRRIGATE = 3'd2,
      S_PAUSE    = 3'd3,
      S_FAULT    = 3'd4
   } state_t;

   state_t            st, nxt_st;
   logic [ZW-1:0]     ptr, nxt_ptr, nxt_active, miss_cnt, nxt_miss;
   logic [CNT_W-1:0]  nxt_rem;
   logic [PW-1:0]     presc;
   logic              sprinkler_mode, nxt_mode;
   logic              tick, conflict, fault, slot_end;

   assign conflict = (mid_water_level & ~low_water_level) |
                     (high_water_level & ~mid_water_level) |
                     (high_water_level & ~low_water_level);
   assign fault    = conflict | ~low_water_level;
   assign tick     = (presc == PW'(TICK_DIV - 1));
   assign slot_end = earth_humidity[active_zone] | (tick & (remaining == CNT_W'(1)));
   assign state    = st;

   function automatic logic [ZW-1:0] wrap_inc(input logic [ZW-1:0] z);
      return (z == ZW'(N_ZONES - 1)) ? '0 : z + ZW'(1);
   endfunction

   always_comb begin
      nxt_st     = st;
      nxt_ptr    = ptr;
      nxt_active = active_zone;
      nxt_rem    = remaining;
      nxt_mode   = sprinkler_mode;
      nxt_miss   = '0;
      if (fault) begin
         // fault beats a coinciding slot end, so the pointer is not advanced
         nxt_st  = S_FAULT;
         nxt_rem = '0;
      end else if (!enable) begin
         nxt_st = S_IDLE;
      end else begin
         case (st)
            S_IDLE: nxt_st = S_SCAN;
            S_SCAN: begin
               if (!earth_humidity[ptr]) begin
                  nxt_st     = S_IRRIGATE;
                  nxt_active = ptr;
                  nxt_rem    = IRR_LOAD;
                  nxt_mode   = mid_water_level & ~air_humidity & ~low_temperature;
               end else begin
                  nxt_ptr = wrap_inc(ptr);
                  if (miss_cnt == ZW'(N_ZONES - 1)) nxt_st = S_IDLE;
                  else                              nxt_miss = miss_cnt + ZW'(1);
               end
            end
            S_IRRIGATE: begin
               if (slot_end) begin
                  nxt_ptr = wrap_inc(active_zone);
                  if (PAUSE_ON) begin
                     nxt_st  = S_PAUSE;
                     nxt_rem = PAUSE_LOAD;
                  end else begin
                     nxt_st  = S_SCAN;
                     nxt_rem = '0;
                  end
               end else if (tick) begin
                  nxt_rem = remaining - CNT_W'(1);
               end
            end
            S_PAUSE: begin
`ifdef IRRIGATION_PAUSE_EN
               if (tick) begin
                  nxt_rem = remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) nxt_st = S_SCAN;
               end
`else
               nxt_st = S_IDLE;
`endif
            end
            S_FAULT: nxt_st = S_IDLE;
            default: nxt_st = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st                   <= S_IDLE;
         ptr                  <= '0;
         miss_cnt             <= '0;
         presc                <= '0;
         sprinkler_mode       <= 1'b0;
         active_zone          <= '0;
         remaining            <= '0;
         zone_valve           <= '0;
         splinker_bomb        <= 1'b0;
         dripper_valvule      <= 1'b0;
         water_supply_valvule <= 1'b0;
         alarm                <= 1'b0;
      end else begin
         st             <= nxt_st;
         ptr            <= nxt_ptr;
         miss_cnt       <= nxt_miss;
         sprinkler_mode <= nxt_mode;
         active_zone    <= nxt_active;
         remaining      <= nxt_rem;
         // restart the prescaler on slot/pause entry so the first tick is full length
         if ((nxt_st == S_IRRIGATE || nxt_st == S_PAUSE) && nxt_st != st) presc <= '0;
         else if (tick)                                                  presc <= '0;
         else                                                            presc <= presc + PW'(1);
         zone_valve      <= (nxt_st == S_IRRIGATE) ? (N_ZONES'(1) << nxt_active) : '0;
         splinker_bomb   <= (nxt_st == S_IRRIGATE) &  nxt_mode;
         dripper_valvule <= (nxt_st == S_IRRIGATE) & ~nxt_mode;
         water_supply_valvule <= ~high_water_level & ~conflict;
         alarm                <= conflict | ~mid_water_level;
      end
   end
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
module tb_irrigation_zone_scheduler;
   localparam int N = 4, TD = 4, IT = 3, PT = 2, CW = 8;
   localparam int SLOT_CYC = IT * TD;
`ifdef IRRIGATION_PAUSE_EN
   localparam int PAUSE_CYC = PT * TD;
   localparam int END_REM = PT;
   localparam int END_ST = 3;
`else
   localparam int PAUSE_CYC = 0;
   localparam int END_REM = 0;
   localparam int END_ST = 1;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic low_water_level, mid_water_level, high_water_level;
   logic [N-1:0] earth_humidity;
   logic air_humidity, low_temperature, enable;
   logic [N-1:0] zone_valve;
   logic splinker_bomb, dripper_valvule, water_supply_valvule, alarm;
   logic [1:0] active_zone;
   logic [CW-1:0] remaining;
   logic [2:0] state;
   int checks = 0, failures = 0;
   int model_ptr = 0;

   irrigation_zone_scheduler #(.N_ZONES(N), .TICK_DIV(TD), .IRRIGATE_TICKS(IT),
                               .PAUSE_TICKS(PT), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset),
      .low_water_level(low_water_level), .mid_water_level(mid_water_level),
      .high_water_level(high_water_level), .earth_humidity(earth_humidity),
      .air_humidity(air_humidity), .low_temperature(low_temperature), .enable(enable),
      .zone_valve(zone_valve), .splinker_bomb(splinker_bomb), .dripper_valvule(dripper_valvule),
      .water_supply_valvule(water_supply_valvule), .alarm(alarm),
      .active_zone(active_zone), .remaining(remaining), .state(state));

   always #5 clock = ~clock;

   // first dry bed at or after ptr, and how many humid beds are skipped to reach it
   function automatic int find_dry(input int ptr, input logic [N-1:0] pat, output int misses);
      for (int i = 0; i < N; i++) begin
         if (!pat[(ptr + i) % N]) begin
            misses = i;
            return (ptr + i) % N;
         end
      end
      misses = N;
      return -1;
   endfunction

   function automatic bit conflict_of(input bit l, input bit m, input bit h);
      return (m && !l) || (h && !m) || (h && !l);
   endfunction

   task automatic set_levels(input bit l, input bit m, input bit h);
      low_water_level = l; mid_water_level = m; high_water_level = h;
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; earth_humidity = '1;
      set_levels(1, 1, 1); air_humidity = 1'b0; low_temperature = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0; model_ptr = 0;
      @(negedge clock);
   endtask

   task automatic wait_open(output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (zone_valve == '0 && n < 200);
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1; enable = 1'b0; earth_humidity = '1; set_levels(1, 1, 1);
      air_humidity = 1'b0; low_temperature = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({zone_valve, splinker_bomb, dripper_valvule, water_supply_valvule, alarm,
           active_zone, remaining, state} !== '0)
         begin failures++; $display("FAIL reset_held outputs=%h expected 0", {zone_valve, splinker_bomb,
            dripper_valvule, water_supply_valvule, alarm, active_zone, remaining, state}); end
      reset = 1'b0; @(negedge clock);
      earth_humidity = 4'b1101; enable = 1'b1;
      wait_open(n);
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({zone_valve, splinker_bomb, dripper_valvule} !== '0)
         begin failures++; $display("FAIL reset_async valves=%b pump=%b drip=%b expected 0", zone_valve, splinker_bomb, dripper_valvule); end
      checks++;
      if (state !== 3'd0 || remaining !== '0 || active_zone !== '0)
         begin failures++; $display("FAIL reset_async_state state=%0d rem=%0d zone=%0d expected 0", state, remaining, active_zone); end
      enable = 1'b0;
      @(negedge clock); reset = 1'b0; model_ptr = 0;
      @(negedge clock);
      checks++;
      if (state !== 3'd0 || zone_valve !== '0)
         begin failures++; $display("FAIL reset_release state=%0d valves=%b expected 0", state, zone_valve); end
   endtask

   task automatic test_levels();
      logic [2:0] lv;
      bit c, f;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         lv = 3'($urandom());
         set_levels(lv[0], lv[1], lv[2]);
         @(negedge clock);
         c = conflict_of(lv[0], lv[1], lv[2]);
         f = c || !lv[0];
         checks++;
         if (alarm !== (c || !lv[1]))
            begin failures++; $display("FAIL levels_alarm lv=%b got=%b exp=%b", lv, alarm, c || !lv[1]); end
         checks++;
         if (water_supply_valvule !== (!lv[2] && !c))
            begin failures++; $display("FAIL levels_supply lv=%b got=%b exp=%b", lv, water_supply_valvule, !lv[2] && !c); end
         checks++;
         if (state !== (f ? 3'd4 : 3'd0))
            begin failures++; $display("FAIL levels_state lv=%b got=%0d exp=%0d", lv, state, f ? 4 : 0); end
      end
   endtask

   task automatic test_round_robin();
      int z, miss, gap, exp_gap, k;
      bit exp_spr, spr_late, bad_rem, c;
      do_reset();
      for (int s = 0; s < 12; s++) begin
         if (s < 3) earth_humidity = 4'b0101;
         else begin
            earth_humidity = N'($urandom());
            if (earth_humidity == '1) earth_humidity = 4'b1110;
         end
         case ($urandom_range(0, 2))
            0: set_levels(1, 1, 1);
            1: set_levels(1, 1, 0);
            default: set_levels(1, 0, 0);
         endcase
         air_humidity = 1'($urandom_range(0, 1));
         low_temperature = 1'($urandom_range(0, 1));
         exp_spr = mid_water_level && !air_humidity && !low_temperature;
         c = conflict_of(low_water_level, mid_water_level, high_water_level);
         z = find_dry(model_ptr, earth_humidity, miss);
         exp_gap = (s == 0) ? miss + 1 : PAUSE_CYC + miss + 1;
         gap = (s == 0) ? 0 : 1;
         enable = 1'b1;
         @(negedge clock);
         while (zone_valve == '0 && gap < 100) begin
            gap++;
            @(negedge clock);
         end
         checks++;
         if (gap != exp_gap)
            begin failures++; $display("FAIL rr_gap slot=%0d got=%0d exp=%0d", s, gap, exp_gap); end
         checks++;
         if (zone_valve !== N'(1 << z) || active_zone !== 2'(z) || state !== 3'd2)
            begin failures++; $display("FAIL rr_zone slot=%0d valves=%b zone=%0d state=%0d exp_zone=%0d", s, zone_valve, active_zone, state, z); end
         checks++;
         if (splinker_bomb !== exp_spr || dripper_valvule !== !exp_spr)
            begin failures++; $display("FAIL rr_mode slot=%0d pump=%b drip=%b exp_pump=%b", s, splinker_bomb, dripper_valvule, exp_spr); end
         checks++;
         if (alarm !== (c || !mid_water_level) || water_supply_valvule !== (!high_water_level && !c))
            begin failures++; $display("FAIL rr_levels slot=%0d alarm=%b supply=%b", s, alarm, water_supply_valvule); end
         k = 0; bad_rem = 1'b0; spr_late = exp_spr;
         while (zone_valve != '0 && k < 100) begin
            if (remaining !== CW'(IT - k / TD)) bad_rem = 1'b1;
            if (k == TD) begin air_humidity = ~air_humidity; low_temperature = ~low_temperature; end
            if (k == SLOT_CYC - 1) spr_late = splinker_bomb;
            k++;
            @(negedge clock);
         end
         checks++;
         if (bad_rem) begin failures++; $display("FAIL rr_remaining slot=%0d countdown differs from ticks", s); end
         checks++;
         if (spr_late !== exp_spr)
            begin failures++; $display("FAIL rr_mode_hold slot=%0d got=%b exp=%b", s, spr_late, exp_spr); end
         checks++;
         if (k != SLOT_CYC || remaining !== CW'(END_REM) || state !== 3'(END_ST))
            begin failures++; $display("FAIL rr_slot_end slot=%0d len=%0d rem=%0d state=%0d exp_len=%0d", s, k, remaining, state, SLOT_CYC); end
         model_ptr = (z + 1) % N;
      end
   endtask

   task automatic test_mode();
      int n;
      do_reset();
      earth_humidity = 4'b1110; enable = 1'b1;
      wait_open(n);
      checks++;
      if (splinker_bomb !== 1'b1 || dripper_valvule !== 1'b0)
         begin failures++; $display("FAIL mode_sprinkler pump=%b drip=%b expected 1 0", splinker_bomb, dripper_valvule); end
      air_humidity = 1'b1; low_temperature = 1'b1;
      repeat (4) @(negedge clock);
      checks++;
      if (splinker_bomb !== 1'b1 || dripper_valvule !== 1'b0)
         begin failures++; $display("FAIL mode_midslot pump=%b drip=%b expected 1 0", splinker_bomb, dripper_valvule); end
      air_humidity = 1'b0; low_temperature = 1'b0;
      n = 0;
      while (zone_valve != '0 && n < 100) begin n++; @(negedge clock); end
      set_levels(1, 0, 0);
      wait_open(n);
      checks++;
      if (dripper_valvule !== 1'b1 || splinker_bomb !== 1'b0 || alarm !== 1'b1 || zone_valve !== 4'b0001)
         begin failures++; $display("FAIL mode_dripper drip=%b pump=%b alarm=%b valves=%b", dripper_valvule, splinker_bomb, alarm, zone_valve); end
   endtask

   task automatic test_fault();
      int n;
      do_reset();
      earth_humidity = 4'b0101; enable = 1'b1;
      for (int f = 0; f < 2; f++) begin
         wait_open(n);
         checks++;
         if (zone_valve !== 4'b0010)
            begin failures++; $display("FAIL fault_pre_zone round=%0d got=%b exp=0010", f, zone_valve); end
         repeat ((f == 0) ? 2 : SLOT_CYC - 1) @(negedge clock);
         mid_water_level = 1'b0;
         @(negedge clock);
         checks++;
         if (state !== 3'd4 || {zone_valve, splinker_bomb, dripper_valvule} !== '0)
            begin failures++; $display("FAIL fault_entry round=%0d state=%0d valves=%b pump=%b drip=%b", f, state, zone_valve, splinker_bomb, dripper_valvule); end
         checks++;
         if (alarm !== 1'b1 || water_supply_valvule !== 1'b0)
            begin failures++; $display("FAIL fault_levels round=%0d alarm=%b supply=%b exp 1 0", f, alarm, water_supply_valvule); end
         repeat (3) @(negedge clock);
         checks++;
         if (state !== 3'd4 || remaining !== '0)
            begin failures++; $display("FAIL fault_hold round=%0d state=%0d rem=%0d", f, state, remaining); end
         mid_water_level = 1'b1;
         @(negedge clock);
         checks++;
         if (state !== 3'd0) begin failures++; $display("FAIL fault_exit round=%0d got=%0d exp=0", f, state); end
         @(negedge clock);
         checks++;
         if (state !== 3'd1) begin failures++; $display("FAIL fault_rescan round=%0d got=%0d exp=1", f, state); end
      end
      wait_open(n);
      checks++;
      if (zone_valve !== 4'b0010)
         begin failures++; $display("FAIL fault_ptr_kept got=%b exp=0010", zone_valve); end
   endtask

   task automatic test_early_finish();
      int z, miss, n, k;
      do_reset();
      earth_humidity = '0; enable = 1'b1;
      for (int s = 0; s < 5; s++) begin
         z = find_dry(model_ptr, earth_humidity, miss);
         wait_open(n);
         checks++;
         if (zone_valve !== N'(1 << z))
            begin failures++; $display("FAIL early_zone slot=%0d got=%b exp_zone=%0d", s, zone_valve, z); end
         k = $urandom_range(1, SLOT_CYC - 2);
         repeat (k) @(negedge clock);
         earth_humidity[z] = 1'b1;
         @(negedge clock);
         checks++;
         if (zone_valve !== '0 || remaining !== CW'(END_REM) || state !== 3'(END_ST))
            begin failures++; $display("FAIL early_end slot=%0d valves=%b rem=%0d state=%0d", s, zone_valve, remaining, state); end
         earth_humidity[z] = 1'b0;
         model_ptr = (z + 1) % N;
      end
   endtask

   task automatic test_all_humid();
      int n;
      do_reset();
      earth_humidity = '1; enable = 1'b1;
      n = 0;
      @(negedge clock);
      while (state == 3'd1 && n < 20) begin n++; @(negedge clock); end
      checks++;
      if (n != N) begin failures++; $display("FAIL humid_scan_len got=%0d exp=%0d", n, N); end
      checks++;
      if (state !== 3'd0 || zone_valve !== '0)
         begin failures++; $display("FAIL humid_idle state=%0d valves=%b exp 0", state, zone_valve); end
      earth_humidity = 4'b0111;
      wait_open(n);
      checks++;
      if (zone_valve !== 4'b1000) begin failures++; $display("FAIL humid_then_dry got=%b exp=1000", zone_valve); end
   endtask

   task automatic test_disable();
      int n;
      do_reset();
      earth_humidity = 4'b1011; enable = 1'b1;
      wait_open(n);
      repeat (2) @(negedge clock);
      enable = 1'b0;
      @(negedge clock);
      checks++;
      if (state !== 3'd0 || {zone_valve, splinker_bomb, dripper_valvule} !== '0)
         begin failures++; $display("FAIL disable state=%0d valves=%b pump=%b drip=%b", state, zone_valve, splinker_bomb, dripper_valvule); end
      enable = 1'b1;
      wait_open(n);
      checks++;
      if (zone_valve !== 4'b0100) begin failures++; $display("FAIL disable_resume got=%b exp=0100", zone_valve); end
   endtask

   initial begin
      test_reset();
      test_levels();
      test_round_robin();
      test_mode();
      test_fault();
      test_early_finish();
      test_all_humid();
      test_disable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
